// File: rtl/decomp_seq_ctrl.sv
// Purpose : decompression sequencer; walks imem by PC, passes plain words, expands tokens via the token table.
// Latency : plain word 0 cycles (combinational from imem); each token word costs TT_LAT+1 cycles.
// Backpress: out_ready_i low freezes PC, state and held word; an outstanding table read still lands, then waits in EXPAND.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   pc_redirect_i/target  load a new PC and flush in-flight work (highest priority)
//   imem_addr_o/rd_i      instruction memory word address and combinational read data
//   tt_req_o/index/word   token-table read strobe, token index, word number
//   tt_data_i/len_i       token-table data and token length, valid TT_LAT cycles after the strobe
//   out_valid/ready/instr/pc  instruction stream to the decoder buffer
//   busy_o                a token is being looked up or expanded
module decomp_seq_ctrl #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 23,
  parameter int TOKEN_MAX = 4,
  parameter int TT_LAT    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_redirect_i,
  input  logic [SIZE-1:0]  pc_target_i,
  output logic [SIZE-1:0]  imem_addr_o,
  input  logic [WIDTH-1:0] imem_rd_i,
  output logic             tt_req_o,
  output logic [7:0]       tt_index_o,
  output logic [2:0]       tt_word_o,
  input  logic [WIDTH-1:0] tt_data_i,
  input  logic [3:0]       tt_len_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_instr_o,
  output logic [SIZE-1:0]  out_pc_o,
  output logic             busy_o
);

  localparam int         LCW  = (TT_LAT > 1) ? $clog2(TT_LAT) : 1;
  localparam logic [3:0] TMAX = 4'(TOKEN_MAX);

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_LOOKUP, ST_EXPAND} state_t;

  state_t           state, state_nxt;
  logic [SIZE-1:0]  pc, pc_nxt;
  logic [2:0]       k, k_nxt;
  logic [3:0]       len, len_nxt;
  logic [WIDTH-1:0] held, held_nxt;
  logic [7:0]       idx, idx_nxt;
  logic [LCW-1:0]   lat_cnt, lat_cnt_nxt;

  logic       is_token;
  logic       lat_done;
  logic [3:0] len_cap;
  logic [3:0] len_eff;
  logic [3:0] k_inc;

  assign is_token = (imem_rd_i[31:28] == 4'hF);
  assign lat_done = (lat_cnt == LCW'(TT_LAT - 1));
  assign len_cap  = (tt_len_i > TMAX) ? TMAX : tt_len_i;
  // Length only arrives with word 0; later words reuse the latched value.
  assign len_eff  = (k == 3'd0) ? len_cap : len;
  assign k_inc    = {1'b0, k} + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_RST;
      pc      <= '0;
      k       <= '0;
      len     <= '0;
      held    <= '0;
      idx     <= '0;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      k       <= k_nxt;
      len     <= len_nxt;
      held    <= held_nxt;
      idx     <= idx_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    k_nxt       = k;
    len_nxt     = len;
    held_nxt    = held;
    idx_nxt     = idx;
    lat_cnt_nxt = lat_cnt;
    imem_addr_o = pc;
    out_pc_o    = pc;
    tt_index_o  = idx;
    tt_word_o   = k;
    tt_req_o    = 1'b0;
    out_valid_o = 1'b0;
    out_instr_o = '0;
    busy_o      = (state == ST_LOOKUP) || (state == ST_EXPAND);

    case (state)
      ST_RST: begin
        imem_addr_o = '0;
        out_pc_o    = '0;
        tt_index_o  = '0;
        tt_word_o   = '0;
        state_nxt   = ST_FETCH;
      end
      ST_FETCH: begin
        if (is_token) begin
          idx_nxt     = imem_rd_i[7:0];
          tt_index_o  = imem_rd_i[7:0];
          tt_req_o    = 1'b1;
          tt_word_o   = 3'd0;
          k_nxt       = 3'd0;
          lat_cnt_nxt = '0;
          state_nxt   = ST_LOOKUP;
        end else begin
          out_valid_o = 1'b1;
          out_instr_o = imem_rd_i;
          if (out_ready_i) pc_nxt = pc + SIZE'(1);
        end
      end
      ST_LOOKUP: begin
        if (lat_done) begin
          held_nxt = tt_data_i;
          if (k == 3'd0) len_nxt = len_cap;
          if (len_eff == 4'd0) begin
            pc_nxt    = pc + SIZE'(1);
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_EXPAND;
          end
        end else begin
          lat_cnt_nxt = lat_cnt + LCW'(1);
        end
      end
      ST_EXPAND: begin
        out_valid_o = 1'b1;
        out_instr_o = held;
        if (out_ready_i) begin
          if (k_inc == len) begin
            pc_nxt    = pc + SIZE'(1);
            k_nxt     = 3'd0;
            state_nxt = ST_FETCH;
          end else begin
            k_nxt       = k_inc[2:0];
            tt_req_o    = 1'b1;
            tt_word_o   = k_inc[2:0];
            lat_cnt_nxt = '0;
            state_nxt   = ST_LOOKUP;
          end
        end
      end
      default: state_nxt = ST_RST;
    endcase

    // Redirect overrides everything decided above; any table data still
    // in flight is never captured because LOOKUP restarts only on a new strobe.
    if (pc_redirect_i && (state != ST_RST)) begin
      out_valid_o = 1'b0;
      tt_req_o    = 1'b0;
      pc_nxt      = pc_target_i;
      k_nxt       = 3'd0;
      lat_cnt_nxt = '0;
      len_nxt     = len;
      held_nxt    = held;
      idx_nxt     = idx;
      state_nxt   = ST_FETCH;
    end
  end

endmodule

// File: tb/tb_decomp_seq_ctrl.sv
module tb_decomp_seq_ctrl;
  localparam int WIDTH = 32, SIZE = 23, TOKEN_MAX = 4, TT_LAT = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pc_redirect_i = 1'b0;
  logic [SIZE-1:0]  pc_target_i = '0;
  logic [SIZE-1:0]  imem_addr_o;
  logic [WIDTH-1:0] imem_rd_i;
  logic             tt_req_o;
  logic [7:0]       tt_index_o;
  logic [2:0]       tt_word_o;
  logic [WIDTH-1:0] tt_data_i = '0;
  logic [3:0]       tt_len_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [WIDTH-1:0] out_instr_o;
  logic [SIZE-1:0]  out_pc_o;
  logic             busy_o;

  decomp_seq_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .TOKEN_MAX(TOKEN_MAX), .TT_LAT(TT_LAT)) dut (
    .clk(clk), .reset(reset), .pc_redirect_i(pc_redirect_i), .pc_target_i(pc_target_i),
    .imem_addr_o(imem_addr_o), .imem_rd_i(imem_rd_i), .tt_req_o(tt_req_o),
    .tt_index_o(tt_index_o), .tt_word_o(tt_word_o), .tt_data_i(tt_data_i),
    .tt_len_i(tt_len_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] WA = 32'hAAAA_0001, WB = 32'hBBBB_0002, WC = 32'hCCCC_0003;

  // Memories: imem defaults to a plain word tagged with its own address.
  logic [31:0] imem_map [int];
  logic [31:0] tt_mem [0:255][0:7];
  logic [3:0]  tt_len_mem [0:255];
  int          imem_gen = 0;

  function automatic logic [31:0] imem_word(logic [SIZE-1:0] a);
    if (imem_map.exists(int'(a))) return imem_map[int'(a)];
    return 32'h1000_0000 | {9'd0, a};
  endfunction

  always @(imem_addr_o or imem_gen) imem_rd_i = imem_word(imem_addr_o);

  // Token table with one cycle of read latency.
  always @(negedge clk) begin
    if (tt_req_o) begin
      tt_data_i = tt_mem[tt_index_o][tt_word_o];
      tt_len_i  = tt_len_mem[tt_index_o];
    end
  end

  int total = 0, bad = 0, cyc = 0, req_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: the program expanded into the instruction stream it must produce.
  typedef struct { logic [31:0] instr; logic [SIZE-1:0] pc; } exp_t;
  exp_t            exp_q[$];
  logic [SIZE-1:0] model_pc = '0;

  task automatic refill();
    logic [31:0] w;
    int          n;
    for (int g = 0; g < 64 && exp_q.size() == 0; g++) begin
      w = imem_word(model_pc);
      if (w[31:28] == 4'hF) begin
        n = int'(tt_len_mem[w[7:0]]);
        if (n > TOKEN_MAX) n = TOKEN_MAX;
        for (int j = 0; j < n; j++) exp_q.push_back('{tt_mem[w[7:0]][j], model_pc});
      end else begin
        exp_q.push_back('{w, model_pc});
      end
      model_pc = model_pc + SIZE'(1);
    end
  endtask

  logic [31:0]     acc_instr[$];
  logic [SIZE-1:0] acc_pc[$];
  int              acc_cyc[$];
  logic            hold_vld = 1'b0;
  logic [31:0]     hold_instr;
  logic [SIZE-1:0] hold_pc;

  task automatic clear_log();
    acc_instr.delete(); acc_pc.delete(); acc_cyc.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (tt_req_o) req_cnt++;
    if (!reset) begin
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_req", 64'(tt_req_o), 64'd0);
      model_pc = '0;
      exp_q.delete();
      hold_vld = 1'b0;
    end else if (pc_redirect_i) begin
      check("redir_valid", 64'(out_valid_o), 64'd0);
      check("redir_req", 64'(tt_req_o), 64'd0);
      model_pc = pc_target_i;
      exp_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("hold_valid", 64'(out_valid_o), 64'd1);
        check("hold_instr", 64'(out_instr_o), 64'(hold_instr));
        check("hold_pc", 64'(out_pc_o), 64'(hold_pc));
      end
      if (out_valid_o && out_ready_i) begin
        refill();
        if (exp_q.size() == 0) begin
          check("model_empty", 64'(out_instr_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_instr", 64'(out_instr_o), 64'(e.instr));
          check("out_pc", 64'(out_pc_o), 64'(e.pc));
        end
        acc_instr.push_back(out_instr_o);
        acc_pc.push_back(out_pc_o);
        acc_cyc.push_back(cyc);
        hold_vld = 1'b0;
      end else if (out_valid_o) begin
        hold_vld   = 1'b1;
        hold_instr = out_instr_o;
        hold_pc    = out_pc_o;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic redirect(logic [SIZE-1:0] tgt);
    pc_redirect_i = 1'b1;
    pc_target_i   = tgt;
    clear_log();
    tick();
    pc_redirect_i = 1'b0;
  endtask

  // Returns one cycle after the given instruction is accepted.
  task automatic wait_accept(string name, logic [31:0] instr, int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (out_valid_o && out_ready_i && out_instr_o == instr) found = 1'b1;
    end
    check(name, 64'(found), 64'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n32;
    int r0;
    logic found;
    for (int i = 0; i < 256; i++) begin
      tt_len_mem[i] = 4'd1;
      for (int j = 0; j < 8; j++) tt_mem[i][j] = 32'hDEAD_0000 | (32'(i) << 4) | 32'(j);
    end
    tt_len_mem[5] = 4'd3;
    tt_mem[5][0] = WA; tt_mem[5][1] = WB; tt_mem[5][2] = WC;
    tt_len_mem[7] = 4'd0;
    tt_len_mem[9] = 4'd9;
    for (int j = 0; j < 8; j++) tt_mem[9][j] = 32'h9900_0000 + 32'(j);
    imem_map[32'h10] = 32'hF000_0005;
    imem_map[32'h30] = 32'hF000_0007;
    imem_map[32'h32] = 32'hF000_0009;
    imem_gen++;

    // Reset state
    repeat (3) tick();
    check("rst_imem_addr", 64'(imem_addr_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_out_pc", 64'(out_pc_o), 64'd0);

    // 1: plain stream, one per cycle
    reset = 1'b1;
    clear_log();
    repeat (8) tick();
    check("t1_count", 64'(acc_pc.size() >= 4), 64'd1);
    check("t1_pc0", 64'(acc_pc[0]), 64'd0);
    check("t1_pc3", 64'(acc_pc[3]), 64'd3);
    check("t1_rate", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);

    // 2: token of three words
    redirect(23'h10);
    wait_accept("t2_wait", 32'h1000_0011, 30);
    check("t2_a", 64'(acc_instr[0]), 64'(WA));
    check("t2_b", 64'(acc_instr[1]), 64'(WB));
    check("t2_c", 64'(acc_instr[2]), 64'(WC));
    check("t2_pc_c", 64'(acc_pc[2]), 64'h10);
    check("t2_next_pc", 64'(acc_pc[3]), 64'h11);
    check("t2_gap_ab", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
    check("t2_gap_bc", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);
    check("t2_gap_c1", 64'(acc_cyc[3] - acc_cyc[2]), 64'd1);

    // 3: stall at B
    redirect(23'h10);
    wait_accept("t3_wait_a", WA, 20);
    out_ready_i = 1'b0;
    r0 = req_cnt;
    repeat (5) tick();
    check("t3_no_req", 64'(req_cnt - r0), 64'd0);
    check("t3_b_valid", 64'(out_valid_o), 64'd1);
    check("t3_b_held", 64'(out_instr_o), 64'(WB));
    out_ready_i = 1'b1;
    wait_accept("t3_wait_end", 32'h1000_0011, 20);
    check("t3_seq_b", 64'(acc_instr[1]), 64'(WB));
    check("t3_seq_c", 64'(acc_instr[2]), 64'(WC));

    // 4: redirect while looking up word 1
    redirect(23'h10);
    wait_accept("t4_wait_a", WA, 20);
    check("t4_in_lookup", 64'({busy_o, out_valid_o}), 64'b10);
    redirect(23'h100);
    wait_accept("t4_wait_100", 32'h1000_0100, 10);
    check("t4_first", 64'(acc_instr[0]), 64'h1000_0100);
    check("t4_first_pc", 64'(acc_pc[0]), 64'h100);

    // 5: zero-length token, then a length clamped to TOKEN_MAX
    redirect(23'h30);
    wait_accept("t5_wait", 32'h1000_0033, 40);
    check("t5_skip_pc", 64'(acc_pc[0]), 64'h31);
    n32 = 0;
    foreach (acc_pc[i]) if (acc_pc[i] == 23'h32) n32++;
    check("t5_clamp_cnt", 64'(n32), 64'd4);
    check("t5_d3", 64'(acc_instr[4]), 64'h9900_0003);
    check("t5_total", 64'(acc_instr.size()), 64'd6);

    // 6a: PC wrap
    redirect(23'h7F_FFFF);
    wait_accept("t6_wait_top", 32'h107F_FFFF, 10);
    wait_accept("t6_wait_zero", 32'h1000_0000, 10);
    check("t6_top_pc", 64'(acc_pc[0]), 64'h7F_FFFF);
    check("t6_wrap_pc", 64'(acc_pc[1]), 64'd0);

    // 6b: async reset while expanding
    out_ready_i = 1'b0;
    redirect(23'h10);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid_o && busy_o) found = 1'b1;
    end
    check("t6_reach_expand", 64'(found), 64'd1);
    @(posedge clk); #2;
    check("t6_pre_valid", 64'(out_valid_o), 64'd1);
    reset = 1'b0;
    #1;
    check("t6_async_valid", 64'(out_valid_o), 64'd0);
    check("t6_async_busy", 64'(busy_o), 64'd0);
    check("t6_async_addr", 64'(imem_addr_o), 64'd0);
    tick();
    reset = 1'b1;
    out_ready_i = 1'b1;
    clear_log();
    wait_accept("t6_restart", 32'h1000_0002, 10);
    check("t6_restart_pc0", 64'(acc_pc[0]), 64'd0);
    check("t6_restart_pc1", 64'(acc_pc[1]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
